csa_iter_reducer: RTL and testbench
===================================

# csa_iter_reducer

Iterative multi-operand adder that time-shares one WIDTH-bit 3:2 carry-save compressor to sum a job of up to 15 operands, one operand per cycle. It keeps the running total in redundant sum/carry form, so each operand costs one compressor pass and no carry propagation. A single carry-propagate add resolves the total when the job ends. It sits between an operand producer and a result consumer in the multiplier/ALU support logic, using decoupled valid/ready handshakes on all three channels.

## Interface
- WIDTH, 10, operand/result width; all arithmetic is mod 2^WIDTH
- CNT_W, 4, width of the job operand-count field (max count 2^CNT_W-1)

Ports:
- clock  in  1  sole clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- io_flush  in  1  synchronous abort of the current job
- io_start_valid  in  1  job request valid
- io_start_ready  out  1  block accepts a job
- io_start_bits_count  in  CNT_W  number of operands in the job (0 allowed)
- io_op_valid  in  1  operand valid
- io_op_ready  out  1  block accepts an operand
- io_op_bits  in  WIDTH  operand
- io_out_valid  out  1  result valid
- io_out_ready  in  1  consumer accepts result
- io_out_bits  out  WIDTH  job sum mod 2^WIDTH
- io_busy  out  1  state != IDLE

## Operation
- Registers: state, sum_r[WIDTH], carry_r[WIDTH], remaining[CNT_W], result_r[WIDTH].
- One internal 3:2 compressor instance, bitwise. Inputs are in0=sum_r, in1={carry_r[WIDTH-2:0],1'b0}, in2=io_op_bits; the carry MSB is dropped. The compressor outputs out0 (sum) and out1 (carry).
- IDLE: io_start_ready=1.
  - On start fire with count==0: result_r<=0, go to DONE.
  - On start fire with count>0: sum_r<=0, carry_r<=0, remaining<=count, go to ACCUM.
- ACCUM: io_op_ready=1.
  - On op fire: sum_r<=out0, carry_r<=out1, remaining<=remaining-1.
  - If the fire occurs with remaining==1, go to RESOLVE.
  - Cycles with io_op_valid=0 hold all state (bubbles allowed).
- RESOLVE: result_r <= sum_r + {carry_r[WIDTH-2:0],1'b0}, truncated to WIDTH. Go to DONE. Takes exactly one cycle, with no handshake.
- DONE: io_out_valid=1 and io_out_bits=result_r, held stable until fire. On out fire go to IDLE.
- Readys and valids are functions of state and io_flush only. They never depend on the partner's valid/ready.
- io_flush high, in any state:
  - io_start_ready, io_op_ready and io_out_valid are all forced to 0 that cycle, so no handshake fires.
  - Next state is IDLE. sum_r, carry_r, remaining and result_r are cleared to 0.
  - A pending result in DONE is discarded.
- Start requests presented outside IDLE are not accepted; io_start_ready=0.

## Timing
- Reset values:
  - state=IDLE; all data registers 0.
  - io_start_ready=1, io_op_ready=0, io_out_valid=0, io_out_bits=0, io_busy=0.
- Start accepted at edge t. State is ACCUM (or DONE if count==0) from cycle t+1.
- With back-to-back operands, the first op can fire in cycle t+1.
- Last op fires at edge k. RESOLVE is cycle k+1; io_out_valid=1 from cycle k+2.
- Latency from last-op fire to out_valid is 2 cycles. A count==0 job has 1 cycle from start fire to out_valid.
- Out fire at edge m gives io_start_ready=1 in cycle m+1. There is no same-cycle start/out overlap.
- Throughput: one operand per cycle. Per-job overhead is 3 cycles (start, RESOLVE, out).
- Reset asserted mid-job returns to the reset values immediately (asynchronous). No result is emitted.

## Test plan
- Reset: assert reset mid-ACCUM -> outputs match reset values immediately. After release, io_start_ready=1 and io_busy=0.
- Basic job: count=3, ops 5, 7, 9 back-to-back, io_out_ready=1 -> io_out_bits=21. io_out_valid rises exactly 2 cycles after the op 9 fire.
- Wrap and bubbles: count=3, ops 1000, 30, 100 with 2-cycle gaps between ops -> io_out_bits=106 (1130 mod 1024). State holds during the gaps.
- Edge counts:
  - count=0 -> io_out_bits=0, io_out_valid 1 cycle after start.
  - count=15, all ops 1023 -> io_out_bits=(15*1023) mod 1024 = 1009.
- Backpressure: hold io_out_ready=0 for 5 cycles in DONE -> io_out_valid and io_out_bits stay stable. io_start_ready stays 0 while io_start_valid=1. Start is accepted only in the cycle after out fire.
- Flush: count=4, flush after 2 ops -> IDLE next cycle with no output. A following job (count=2, ops 3, 4) gives io_out_bits=7. Flush asserted in DONE -> result discarded, io_out_valid=0 in the flush cycle.

Source files
------------

// File: rtl/csa_iter_reducer.sv
// Iterative multi-operand adder: one 3:2 carry-save compressor folds in one operand per cycle,
// and a single carry-propagate add resolves the redundant total when the job ends.
module csa_iter_reducer #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_flush,
  input  logic             io_start_valid,
  output logic             io_start_ready,
  input  logic [CNT_W-1:0] io_start_bits_count,
  input  logic             io_op_valid,
  output logic             io_op_ready,
  input  logic [WIDTH-1:0] io_op_bits,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits,
  output logic             io_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_carry;
  logic [CNT_W-1:0] r_remaining;
  logic [WIDTH-1:0] r_result;

  logic [WIDTH-1:0] w_carryShift;
  logic [WIDTH-1:0] w_out0;
  logic [WIDTH-1:0] w_out1;
  logic             w_startFire;
  logic             w_opFire;
  logic             w_outFire;

  // Carry word is stored unshifted; its weight shift (dropping the MSB) happens on use.
  assign w_carryShift = r_carry << 1;
  assign w_out0       = r_sum ^ w_carryShift ^ io_op_bits;
  assign w_out1       = (r_sum & w_carryShift) | (r_sum & io_op_bits) | (w_carryShift & io_op_bits);

  assign io_start_ready = (r_state == IDLE)  && !io_flush;
  assign io_op_ready    = (r_state == ACCUM) && !io_flush;
  assign io_out_valid   = (r_state == DONE)  && !io_flush;
  assign io_out_bits    = r_result;
  assign io_busy        = (r_state != IDLE);

  assign w_startFire = io_start_ready && io_start_valid;
  assign w_opFire    = io_op_ready && io_op_valid;
  assign w_outFire   = io_out_valid && io_out_ready;

  always_comb begin
    w_stateNext = r_state;
    if (io_flush) begin
      w_stateNext = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_startFire) w_stateNext = (io_start_bits_count == '0) ? DONE : ACCUM;
        ACCUM:   if (w_opFire && (r_remaining == CNT_W'(1))) w_stateNext = RESOLVE;
        RESOLVE: w_stateNext = DONE;
        DONE:    if (w_outFire) w_stateNext = IDLE;
        default: w_stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sum       <= '0;
      r_carry     <= '0;
      r_remaining <= '0;
      r_result    <= '0;
    end else if (io_flush) begin
      r_sum       <= '0;
      r_carry     <= '0;
      r_remaining <= '0;
      r_result    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_startFire) begin
            if (io_start_bits_count == '0) begin
              r_result <= '0;
            end else begin
              r_sum       <= '0;
              r_carry     <= '0;
              r_remaining <= io_start_bits_count;
            end
          end
        end
        ACCUM: begin
          if (w_opFire) begin
            r_sum       <= w_out0;
            r_carry     <= w_out1;
            r_remaining <= r_remaining - CNT_W'(1);
          end
        end
        RESOLVE: r_result <= r_sum + w_carryShift;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_iter_reducer.sv
// Directed bench for csa_iter_reducer: table of jobs with hand-computed sums,
// plus hand-written reset, backpressure and flush sequences.
module tb_csa_iter_reducer;

  localparam int WIDTH = 10;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             io_flush;
  logic             io_start_valid;
  logic             io_start_ready;
  logic [CNT_W-1:0] io_start_bits_count;
  logic             io_op_valid;
  logic             io_op_ready;
  logic [WIDTH-1:0] io_op_bits;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out_bits;
  logic             io_busy;

  int nVec  = 0;
  int nFail = 0;

  typedef struct {
    string            name;
    int               count;
    logic [WIDTH-1:0] ops [15];
    int               gap;
    logic [WIDTH-1:0] expected;
  } vec_t;

  vec_t vecs [6];

  csa_iter_reducer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock               (clock),
    .reset               (reset),
    .io_flush            (io_flush),
    .io_start_valid      (io_start_valid),
    .io_start_ready      (io_start_ready),
    .io_start_bits_count (io_start_bits_count),
    .io_op_valid         (io_op_valid),
    .io_op_ready         (io_op_ready),
    .io_op_bits          (io_op_bits),
    .io_out_valid        (io_out_valid),
    .io_out_ready        (io_out_ready),
    .io_out_bits         (io_out_bits),
    .io_busy             (io_busy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVec++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Runs one whole job from start handshake to out handshake, checking the cycle-exact timeline.
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    io_start_valid      = 1'b1;
    io_start_bits_count = v.count[CNT_W-1:0];
    io_out_ready        = 1'b0;
    #1 checkOutput({v.name, " start_ready"}, int'(io_start_ready), 1);
    @(negedge clock);
    io_start_valid = 1'b0;
    if (v.count == 0) begin
      #1 checkOutput({v.name, " out_valid after start"}, int'(io_out_valid), 1);
    end else begin
      for (int i = 0; i < v.count; i++) begin
        if (i > 0) begin
          for (int g = 0; g < v.gap; g++) begin
            io_op_valid = 1'b0;
            #1 checkOutput({v.name, " op_ready in gap"}, int'(io_op_ready), 1);
            @(negedge clock);
          end
        end
        io_op_valid = 1'b1;
        io_op_bits  = v.ops[i];
        #1 checkOutput({v.name, " op_ready"}, int'(io_op_ready), 1);
        @(negedge clock);
      end
      io_op_valid = 1'b0;
      #1 checkOutput({v.name, " out_valid in resolve"}, int'(io_out_valid), 0);
      @(negedge clock);
      #1 checkOutput({v.name, " out_valid 2 after last op"}, int'(io_out_valid), 1);
    end
    checkOutput({v.name, " out_bits"}, int'(io_out_bits), int'(v.expected));
    io_out_ready = 1'b1;
    @(negedge clock);
    io_out_ready = 1'b0;
    #1 checkOutput({v.name, " start_ready after out"}, int'(io_start_ready), 1);
    checkOutput({v.name, " busy after out"}, int'(io_busy), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0].name = "basic";  vecs[0].count = 3;  vecs[0].gap = 0; vecs[0].expected = 10'd21;
    vecs[0].ops[0] = 10'd5;  vecs[0].ops[1] = 10'd7;  vecs[0].ops[2] = 10'd9;
    vecs[1].name = "wrap";   vecs[1].count = 3;  vecs[1].gap = 2; vecs[1].expected = 10'd106;
    vecs[1].ops[0] = 10'd1000; vecs[1].ops[1] = 10'd30; vecs[1].ops[2] = 10'd100;
    vecs[2].name = "count0"; vecs[2].count = 0;  vecs[2].gap = 0; vecs[2].expected = 10'd0;
    vecs[3].name = "max15";  vecs[3].count = 15; vecs[3].gap = 0; vecs[3].expected = 10'd1009;
    for (int i = 0; i < 15; i++) vecs[3].ops[i] = 10'd1023;
    vecs[4].name = "carry";  vecs[4].count = 4;  vecs[4].gap = 1; vecs[4].expected = 10'd3;
    vecs[4].ops[0] = 10'd512; vecs[4].ops[1] = 10'd512; vecs[4].ops[2] = 10'd1; vecs[4].ops[3] = 10'd2;
    vecs[5].name = "single"; vecs[5].count = 1;  vecs[5].gap = 0; vecs[5].expected = 10'd1023;
    vecs[5].ops[0] = 10'd1023;

    reset = 1'b1; io_flush = 1'b0; io_start_valid = 1'b0; io_start_bits_count = '0;
    io_op_valid = 1'b0; io_op_bits = '0; io_out_ready = 1'b0;
    #1;
    checkOutput("reset start_ready", int'(io_start_ready), 1);
    checkOutput("reset out_valid", int'(io_out_valid), 0);
    checkOutput("reset busy", int'(io_busy), 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Reset mid-ACCUM after a nonzero result is latched.
    @(negedge clock);
    io_start_valid = 1'b1; io_start_bits_count = 4'd3;
    @(negedge clock);
    io_start_valid = 1'b0; io_op_valid = 1'b1; io_op_bits = 10'd77;
    @(negedge clock);
    io_op_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("midjob reset start_ready", int'(io_start_ready), 1);
    checkOutput("midjob reset op_ready", int'(io_op_ready), 0);
    checkOutput("midjob reset out_valid", int'(io_out_valid), 0);
    checkOutput("midjob reset out_bits", int'(io_out_bits), 0);
    checkOutput("midjob reset busy", int'(io_busy), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1 checkOutput("post reset start_ready", int'(io_start_ready), 1);
    checkOutput("post reset busy", int'(io_busy), 0);

    // Backpressure in DONE with a competing start request.
    @(negedge clock);
    io_start_valid = 1'b1; io_start_bits_count = 4'd1;
    @(negedge clock);
    io_start_valid = 1'b0; io_op_valid = 1'b1; io_op_bits = 10'd42;
    @(negedge clock);
    io_op_valid = 1'b0;
    @(negedge clock);
    io_start_valid = 1'b1; io_start_bits_count = 4'd0; io_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("bp out_valid", int'(io_out_valid), 1);
      checkOutput("bp out_bits", int'(io_out_bits), 42);
      checkOutput("bp start_ready", int'(io_start_ready), 0);
      @(negedge clock);
    end
    io_out_ready = 1'b1;
    #1 checkOutput("bp start_ready at out fire", int'(io_start_ready), 0);
    @(negedge clock);
    io_out_ready = 1'b0;
    #1 checkOutput("bp start_ready after out fire", int'(io_start_ready), 1);
    checkOutput("bp out_valid after out fire", int'(io_out_valid), 0);
    @(negedge clock);
    io_start_valid = 1'b0;
    #1 checkOutput("bp count0 out_valid", int'(io_out_valid), 1);
    checkOutput("bp count0 out_bits", int'(io_out_bits), 0);
    io_out_ready = 1'b1;
    @(negedge clock);
    io_out_ready = 1'b0;

    // Flush in ACCUM after two operands.
    io_start_valid = 1'b1; io_start_bits_count = 4'd4;
    @(negedge clock);
    io_start_valid = 1'b0; io_op_valid = 1'b1; io_op_bits = 10'd1;
    @(negedge clock);
    io_op_bits = 10'd2;
    @(negedge clock);
    io_op_valid = 1'b1; io_op_bits = 10'd5; io_flush = 1'b1;
    #1 checkOutput("flush op_ready", int'(io_op_ready), 0);
    checkOutput("flush start_ready", int'(io_start_ready), 0);
    @(negedge clock);
    io_flush = 1'b0; io_op_valid = 1'b0;
    #1 checkOutput("after flush busy", int'(io_busy), 0);
    checkOutput("after flush start_ready", int'(io_start_ready), 1);
    checkOutput("after flush out_valid", int'(io_out_valid), 0);

    vecs[0].name = "postflush"; vecs[0].count = 2; vecs[0].gap = 0; vecs[0].expected = 10'd7;
    vecs[0].ops[0] = 10'd3; vecs[0].ops[1] = 10'd4;
    applyStimulus(vecs[0]);

    // Flush in DONE discards the pending result.
    @(negedge clock);
    io_start_valid = 1'b1; io_start_bits_count = 4'd1;
    @(negedge clock);
    io_start_valid = 1'b0; io_op_valid = 1'b1; io_op_bits = 10'd9;
    @(negedge clock);
    io_op_valid = 1'b0;
    @(negedge clock);
    #1 checkOutput("done before flush out_valid", int'(io_out_valid), 1);
    io_flush = 1'b1; io_out_ready = 1'b1;
    #1 checkOutput("done flush out_valid", int'(io_out_valid), 0);
    @(negedge clock);
    io_flush = 1'b0; io_out_ready = 1'b0;
    #1 checkOutput("done flush busy", int'(io_busy), 0);
    checkOutput("done flush out_valid next", int'(io_out_valid), 0);
    checkOutput("done flush result cleared", int'(io_out_bits), 0);

    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
